// File: rtl/sudoku_checker.sv
// ---------------------------------------------------------------------------
// sudoku_checker
//   Answers main_FSM's CHECK state. A 0->1 transition on check_flag (seen
//   while idle) snapshots the board and walks all rows, then all columns, then
//   all boxes, one cell per clock. The first bad cell (empty, out of range or
//   a repeated digit within its group) ends the scan early. Otherwise the scan
//   ends after the last box cell. Either way the verdict comes with a
//   one-cycle done pulse.
//
// Ports
//   clka        in   1        single clock, rising edge
//   restart_n   in   1        synchronous active-low reset
//   check_flag  in   1        check request level; a scan starts on 0->1
//   board       in   N*N*CW   cell(r,c) at bits [(r*N+c)*CW +: CW]
//   busy        out  1        scan in progress
//   done        out  1        one-cycle pulse; verdict valid from this cycle
//   solved      out  1        board is a complete valid solution (held)
//   err_idx     out  7        r*N+c of the first failing cell, 127 if none
//   err_phase   out  2        0 none, 1 row, 2 column, 3 box
// ---------------------------------------------------------------------------
module sudoku_checker #(
    parameter int N   = 9,
    parameter int BOX = 3,
    parameter int CW  = 4
) (
    input  logic              clka,
    input  logic              restart_n,
    input  logic              check_flag,
    input  logic [N*N*CW-1:0] board,
    output logic              busy,
    output logic              done,
    output logic              solved,
    output logic [6:0]        err_idx,
    output logic [1:0]        err_phase
);

    localparam int         SW     = (BOX > 1) ? $clog2(BOX) : 1;
    localparam logic [6:0] NO_ERR = 7'd127;

    // The scan-state encodings are also the err_phase codes.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SCAN_ROW = 2'd1,
        SCAN_COL = 2'd2,
        SCAN_BOX = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic          chk_q;
    logic [CW-1:0] snap [N*N];

    // The group and element counters are each split into base-BOX digits
    // (hi = x/BOX, lo = x%BOX). Box coordinates then need no divider.
    logic [SW-1:0] g_hi, g_lo, e_hi, e_lo;
    logic [N-1:0]  seen, seen_nxt, onehot;
    logic [6:0]    g_pos, e_pos, row, col, cell_idx;
    logic [CW-1:0] v;
    logic          v_ok, seen_hit, fail, e_first, g_last, e_last, last, start;

    assign start   = (state == IDLE) && check_flag && !chk_q;
    assign e_first = (e_hi == '0) && (e_lo == '0);
    assign e_last  = (e_hi == SW'(BOX-1)) && (e_lo == SW'(BOX-1));
    assign g_last  = (g_hi == SW'(BOX-1)) && (g_lo == SW'(BOX-1));
    assign last    = g_last && e_last;

    // Work out the current cell and decide whether it fails.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path can leave it unassigned and infer a latch.
        g_pos  = 7'(g_hi) * 7'(BOX) + 7'(g_lo);
        e_pos  = 7'(e_hi) * 7'(BOX) + 7'(e_lo);
        row    = g_pos;
        col    = e_pos;
        onehot = '0;
        unique case (state)
            SCAN_COL: begin
                row = e_pos;
                col = g_pos;
            end
            SCAN_BOX: begin
                row = 7'(g_hi) * 7'(BOX) + 7'(e_hi);
                col = 7'(g_lo) * 7'(BOX) + 7'(e_lo);
            end
            default: ;
        endcase
        cell_idx = row * 7'(N) + col;
        v        = snap[cell_idx];
        v_ok     = (v != '0) && (v <= CW'(N));
        if (v_ok) onehot[v - CW'(1)] = 1'b1;
        seen_hit = !e_first && |(seen & onehot);
        fail     = !v_ok || seen_hit;
        seen_nxt = e_first ? onehot : (seen | onehot);
    end

    // State register
    always_ff @(posedge clka) begin
        // NOTE: sequential state is updated with non-blocking assignments, so every register samples its pre-edge values.
        if (!restart_n) state <= IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic. A bad cell drops straight back to IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (start) state_nxt = SCAN_ROW;
            SCAN_ROW: if (fail) state_nxt = IDLE; else if (last) state_nxt = SCAN_COL;
            SCAN_COL: if (fail) state_nxt = IDLE; else if (last) state_nxt = SCAN_BOX;
            SCAN_BOX: if (fail || last) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy = (state != IDLE);
    end

    // Board snapshot. It is loaded at every start and is only read while busy.
    always_ff @(posedge clka) begin
        // NOTE: the snapshot memory is deliberately not reset; it is always loaded before it is read.
        if (start) begin
            for (int i = 0; i < N*N; i++) snap[i] <= board[i*CW +: CW];
        end
    end

    // Counters, seen mask and registered verdict
    always_ff @(posedge clka) begin
        if (!restart_n) begin
            chk_q     <= 1'b1;    // a request held high through reset must not start a scan
            g_hi      <= '0;
            g_lo      <= '0;
            e_hi      <= '0;
            e_lo      <= '0;
            seen      <= '0;
            done      <= 1'b0;
            solved    <= 1'b0;
            err_idx   <= NO_ERR;
            err_phase <= 2'd0;
        end else begin
            chk_q <= check_flag;
            done  <= 1'b0;
            if (start) begin
                g_hi      <= '0;
                g_lo      <= '0;
                e_hi      <= '0;
                e_lo      <= '0;
                solved    <= 1'b0;
                err_idx   <= NO_ERR;
                err_phase <= 2'd0;
            end else if (busy) begin
                seen <= seen_nxt;
                if (fail) begin
                    done      <= 1'b1;
                    solved    <= 1'b0;
                    err_idx   <= cell_idx;
                    err_phase <= state;
                end else begin
                    // Ripple the base-BOX digits. After the last cell they all
                    // wrap to zero, so the next phase starts at g=e=0.
                    if (e_lo != SW'(BOX-1)) begin
                        e_lo <= e_lo + SW'(1);
                    end else begin
                        e_lo <= '0;
                        if (e_hi != SW'(BOX-1)) begin
                            e_hi <= e_hi + SW'(1);
                        end else begin
                            e_hi <= '0;
                            if (g_lo != SW'(BOX-1)) begin
                                g_lo <= g_lo + SW'(1);
                            end else begin
                                g_lo <= '0;
                                g_hi <= (g_hi == SW'(BOX-1)) ? '0 : g_hi + SW'(1);
                            end
                        end
                    end
                    if (state == SCAN_BOX && last) begin
                        done      <= 1'b1;
                        solved    <= 1'b1;
                        err_idx   <= NO_ERR;
                        err_phase <= 2'd0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sudoku_checker.sv
module tb_sudoku_checker;

    localparam int N   = 9;
    localparam int CW  = 4;
    localparam int BW  = N*N*CW;
    localparam int MAX_WAIT = 300;

    typedef struct {
        int k;        // 1-based scan cell whose edge raises done
        int solved;
        int idx;
        int ph;
    } result_t;

    typedef struct {
        string          name;
        logic [BW-1:0]  b;
        result_t        exp;
    } vec_t;

    logic          clka = 1'b0;
    logic          restart_n = 1'b0;
    logic          check_flag = 1'b0;
    logic [BW-1:0] board = '0;
    logic          busy, done, solved;
    logic [6:0]    err_idx;
    logic [1:0]    err_phase;

    int total = 0;
    int bad   = 0;

    always #5 clka = ~clka;

    sudoku_checker #(.N(N), .BOX(3), .CW(CW)) dut (
        .clka       (clka),
        .restart_n  (restart_n),
        .check_flag (check_flag),
        .board      (board),
        .busy       (busy),
        .done       (done),
        .solved     (solved),
        .err_idx    (err_idx),
        .err_phase  (err_phase)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] set_cell(input logic [BW-1:0] b, input int r, input int c, input int v);
        b[(r*N+c)*CW +: CW] = CW'(v);
        return b;
    endfunction

    function automatic int get_cell(input logic [BW-1:0] b, input int r, input int c);
        return int'(b[(r*N+c)*CW +: CW]);
    endfunction

    function automatic logic [BW-1:0] grid_g();
        logic [BW-1:0] b = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                b = set_cell(b, r, c, ((3*r + r/3 + c) % 9) + 1);
        return b;
    endfunction

    function automatic logic [BW-1:0] grid_latin();
        logic [BW-1:0] b = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                b = set_cell(b, r, c, ((r + c) % 9) + 1);
        return b;
    endfunction

    // Reference model. It walks rows, then columns, then boxes, and reports
    // the first cell that is empty, out of range or repeated in its group.
    function automatic result_t ref_check(input logic [BW-1:0] b);
        result_t res;
        int k = 0;
        res = '{k: 3*N*N, solved: 1, idx: 127, ph: 0};
        for (int ph = 1; ph <= 3; ph++) begin
            for (int g = 0; g < N; g++) begin
                bit seen [0:15];
                foreach (seen[i]) seen[i] = 1'b0;
                for (int e = 0; e < N; e++) begin
                    int r, c, v;
                    if (ph == 1)      begin r = g; c = e; end
                    else if (ph == 2) begin r = e; c = g; end
                    else              begin r = 3*(g/3) + e/3; c = 3*(g%3) + e%3; end
                    k++;
                    v = get_cell(b, r, c);
                    if (v < 1 || v > N || seen[v]) begin
                        res = '{k: k, solved: 0, idx: r*N + c, ph: ph};
                        return res;
                    end
                    seen[v] = 1'b1;
                end
            end
        end
        return res;
    endfunction

    // Relabelled copy of G with an optional random defect.
    function automatic logic [BW-1:0] rand_board();
        int p [N];
        logic [BW-1:0] g = grid_g();
        logic [BW-1:0] b = '0;
        int mode, r, c, c2, t;
        for (int i = 0; i < N; i++) p[i] = i + 1;
        for (int i = N-1; i > 0; i--) begin
            int j = $urandom_range(0, i);
            t = p[i]; p[i] = p[j]; p[j] = t;
        end
        for (int rr = 0; rr < N; rr++)
            for (int cc = 0; cc < N; cc++)
                b = set_cell(b, rr, cc, p[get_cell(g, rr, cc) - 1]);
        mode = $urandom_range(0, 3);
        r    = $urandom_range(0, N-1);
        c    = $urandom_range(0, N-1);
        case (mode)
            1: b = set_cell(b, r, c, $urandom_range(0, 15));
            2: begin
                c2 = $urandom_range(0, N-1);
                t  = get_cell(b, r, c);
                b  = set_cell(b, r, c, get_cell(b, r, c2));
                b  = set_cell(b, r, c2, t);
            end
            3: b = set_cell(b, r, c, $urandom_range(1, N));
            default: ;
        endcase
        return b;
    endfunction

    // Start one scan and compare the verdict, latency and busy length.
    // A non-zero repulse_at re-raises check_flag during the scan. A non-zero
    // change_at overwrites the board input with alt during the scan.
    task automatic run_scan(input string tag, input logic [BW-1:0] b, input result_t exp,
                            input int repulse_at, input int change_at, input logic [BW-1:0] alt);
        result_t got;
        int      busy_cyc;
        got = '{k: -1, solved: -1, idx: -1, ph: -1};
        @(negedge clka);
        check_flag = 1'b0;
        board      = b;
        @(negedge clka);
        check_flag = 1'b1;
        @(posedge clka);  // edge T0
        #1;
        check({tag, " t0_busy"},    int'(busy),    1);
        check({tag, " t0_solved"},  int'(solved),  0);
        check({tag, " t0_err_idx"}, int'(err_idx), 127);
        check_flag = 1'b0;
        busy_cyc   = 1;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(posedge clka);
            #1;
            if (done) begin
                got = '{k: k, solved: int'(solved), idx: int'(err_idx), ph: int'(err_phase)};
                break;
            end
            if (busy) busy_cyc++;
            if (k == change_at) board = alt;
            if (k == repulse_at) check_flag = 1'b1;
            if (k == repulse_at + 2) check_flag = 1'b0;
        end
        check({tag, " latency"},     got.k,      exp.k);
        check({tag, " busy_cycles"}, busy_cyc,   exp.k);
        check({tag, " solved"},      got.solved, exp.solved);
        check({tag, " err_idx"},     got.idx,    exp.idx);
        check({tag, " err_phase"},   got.ph,     exp.ph);
        @(posedge clka);
        #1;
        check({tag, " done_one_cycle"}, int'(done),   0);
        check({tag, " solved_held"},    int'(solved), exp.solved);
    endtask

    vec_t          vecs [5];
    result_t       pass_res;
    logic [BW-1:0] g;
    int            done_seen, busy_seen;

    initial begin
        g        = grid_g();
        pass_res = '{k: 243, solved: 1, idx: 127, ph: 0};
        vecs[0]  = '{"solved_g", g,                                       pass_res};
        vecs[1]  = '{"empty_00", set_cell(g, 0, 0, 0),                    '{k: 1,   solved: 0, idx: 0,  ph: 1}};
        vecs[2]  = '{"swap_r4",  set_cell(set_cell(g, 4, 0, 6), 4, 1, 5), '{k: 89,  solved: 0, idx: 63, ph: 2}};
        vecs[3]  = '{"range_88", set_cell(g, 8, 8, 10),                   '{k: 81,  solved: 0, idx: 80, ph: 1}};
        vecs[4]  = '{"latin",    grid_latin(),                            '{k: 166, solved: 0, idx: 9,  ph: 3}};

        // Reset state, with check_flag held high through the reset release.
        restart_n  = 1'b0;
        check_flag = 1'b1;
        repeat (3) @(negedge clka);
        check("reset busy",      int'(busy),      0);
        check("reset done",      int'(done),      0);
        check("reset solved",    int'(solved),    0);
        check("reset err_idx",   int'(err_idx),   127);
        check("reset err_phase", int'(err_phase), 0);
        restart_n = 1'b1;
        repeat (5) @(negedge clka);
        check("held_flag no_start busy", int'(busy), 0);
        check("held_flag no_start done", int'(done), 0);

        // Directed table
        foreach (vecs[i]) run_scan(vecs[i].name, vecs[i].b, vecs[i].exp, 0, 0, '0);

        // check_flag re-raised at T50 and the board cleared at T10: neither changes the result.
        run_scan("repulse_and_board_change", g, pass_res, 50, 10, '0);

        // Reset at edge T100 aborts the scan with no done pulse.
        @(negedge clka);
        check_flag = 1'b0;
        board      = g;
        @(negedge clka);
        check_flag = 1'b1;
        @(posedge clka);  // T0
        #1;
        check_flag = 1'b0;
        done_seen  = 0;
        for (int k = 1; k <= 99; k++) begin
            @(posedge clka);
            #1;
            if (done) done_seen++;
        end
        restart_n  = 1'b0;
        check_flag = 1'b1;
        @(posedge clka);  // T100 samples reset
        #1;
        check("midreset busy",    int'(busy),    0);
        check("midreset done",    int'(done),    0);
        check("midreset err_idx", int'(err_idx), 127);
        @(negedge clka);
        restart_n = 1'b1;
        busy_seen = 0;
        for (int k = 0; k < 260; k++) begin
            @(negedge clka);
            if (done) done_seen++;
            if (busy) busy_seen++;
        end
        check("midreset no_done_pulse", done_seen, 0);
        check("midreset no_restart",    busy_seen, 0);

        // Random boards against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [BW-1:0] rb;
            rb = rand_board();
            run_scan($sformatf("rand%0d", i), rb, ref_check(rb), 0, 0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
